// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC register and IR fetch stage upstream of the multicycle control unit.
//   clk, Reset (async, active-high)
//   PCSrc/PCWrite/PCWriteCond/BranchOp, alu_zero/alu_lt, alu_result/alu_out -> PC update
//   LoadIR, imem_rdata/imem_ack -> imem_req/imem_addr fetch handshake with timeout
//   pc, instruction, ir_valid, fetch_busy, fetch_err (pulse), misaligned (pulse)
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_00FC,
    parameter int          TIMEOUT    = 8
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [1:0]  PCSrc,
    input  logic        PCWrite,
    input  logic        PCWriteCond,
    input  logic [1:0]  BranchOp,
    input  logic        alu_zero,
    input  logic        alu_lt,
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_out,
    input  logic        LoadIR,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] instruction,
    output logic        ir_valid,
    output logic        fetch_busy,
    output logic        fetch_err,
    output logic        misaligned
);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   pc_q, pc_d, target, instr_q, addr_q;
    logic          req_q, busy_q, valid_q, err_q, mis_q, take, we, bad;
    always_comb begin
        target = PCSrc == 2'b00 ? alu_result : PCSrc == 2'b01 ? alu_out : EXC_VECTOR;
        take   = BranchOp == 2'b00 ? alu_zero : BranchOp == 2'b01 ? !alu_zero :
                 BranchOp == 2'b10 ? !alu_lt : alu_lt;
        // PCSrc=11 is reserved and never writes, regardless of the enables
        we     = PCSrc != 2'b11 && (PCWrite || (PCWriteCond && take));
        bad    = we && target[1:0] != 2'b00;
        pc_d   = we && !bad ? target : pc_q;
    end
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            addr_q  <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            mis_q <= bad;
            err_q <= 1'b0;
            if (state_q == IDLE) begin
                if (LoadIR) begin
                    // pc_q is the pre-update value, so a same-edge PC write does not affect the fetch address
                    addr_q  <= pc_q;
                    req_q   <= 1'b1;
                    busy_q  <= 1'b1;
                    valid_q <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
            end else if (imem_ack) begin
                // ack wins over the timeout boundary
                instr_q <= imem_rdata;
                valid_q <= 1'b1;
                req_q   <= 1'b0;
                busy_q  <= 1'b0;
                state_q <= IDLE;
            end else if (cnt_q == LAST) begin
                req_q   <= 1'b0;
                busy_q  <= 1'b0;
                err_q   <= 1'b1;
                state_q <= IDLE;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
    assign pc          = pc_q;
    assign instruction = instr_q;
    assign imem_addr   = addr_q;
    assign imem_req    = req_q;
    assign fetch_busy  = busy_q;
    assign ir_valid    = valid_q;
    assign fetch_err   = err_q;
    assign misaligned  = mis_q;
endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
PC register and instruction-register stage directly upstream of the multicycle control unit.
- Applies the control unit's PC-update controls (PCSrc, PCWrite, PCWriteCond, BranchOp) and evaluates the branch condition from ALU flags.
- On LoadIR, fetches the instruction at the current PC from instruction memory through a req/ack handshake and holds it in the IR.
- Drives `instruction` back into the control unit.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- EXC_VECTOR, 32'h0000_00FC, PC target when PCSrc=2'b10.
- TIMEOUT, 8, maximum cycles spent waiting for imem_ack before a fetch is aborted (must be ≥1).

Ports:
- clk  in  1  clock
- Reset  in  1  asynchronous, active-high reset
- PCSrc  in  2  PC source: 00 alu_result, 01 alu_out, 10 EXC_VECTOR, 11 reserved
- PCWrite  in  1  unconditional PC write
- PCWriteCond  in  1  PC write gated by branch condition
- BranchOp  in  2  condition: 00 beq, 01 bne, 10 bge, 11 blt
- alu_zero  in  1  ALU result == 0
- alu_lt  in  1  signed A < B from ALU
- alu_result  in  32  combinational ALU output (PC+4 during fetch)
- alu_out  in  32  registered ALUOut (branch/jump target)
- LoadIR  in  1  fetch request from control unit
- imem_rdata  in  32  instruction memory read data
- imem_ack  in  1  memory data valid
- imem_req  out  1  memory request, level, held until ack or abort
- imem_addr  out  32  latched fetch address
- pc  out  32  current PC
- instruction  out  32  IR contents
- ir_valid  out  1  IR holds a completed fetch
- fetch_busy  out  1  fetch in flight
- fetch_err  out  1  one-cycle pulse on fetch timeout
- misaligned  out  1  one-cycle pulse when a PC write is rejected

Behaviour:
Reset (asynchronous, immediate):
- pc=RESET_PC, instruction=0, imem_addr=0.
- ir_valid, imem_req, fetch_busy, fetch_err and misaligned all 0.
- FSM goes to IDLE.
- A reset during an in-flight fetch drops imem_req in the same instant. A later ack is ignored.

PC update (evaluated every clk edge):
- Target: PCSrc 00 → alu_result, 01 → alu_out, 10 → EXC_VECTOR, 11 → no write.
- Branch taken (take):
  - beq: alu_zero
  - bne: !alu_zero
  - bge: !alu_lt
  - blt: alu_lt
- Write enable: we = PCWrite | (PCWriteCond & take). If PCWrite and PCWriteCond are both high, PCWrite wins and the write is unconditional.
- Misaligned target: if we and target[1:0] != 2'b00, pc is held and misaligned pulses high for 1 cycle.
- Otherwise pc <= target on that edge, visible on the next cycle.
- PC updates are independent of fetch state.

Fetch FSM:
- IDLE:
  - LoadIR=1 at an edge: imem_addr<=pc, imem_req<=1, fetch_busy<=1, ir_valid<=0, counter<=0, go to WAIT.
  - If a PC write occurs on the same edge, imem_addr takes the old pc.
- WAIT:
  - imem_ack=1: instruction<=imem_rdata, ir_valid<=1, imem_req<=0, fetch_busy<=0, go to IDLE.
  - No ack, counter==TIMEOUT-1: imem_req<=0, fetch_busy<=0, fetch_err pulses for 1 cycle, instruction unchanged, ir_valid stays 0, go to IDLE.
  - No ack otherwise: counter increments.
  - LoadIR in WAIT is ignored; there is no queueing.
  - An ack in the same cycle as the timeout boundary counts as success.
- Latency: imem_req rises 1 cycle after LoadIR is sampled. instruction/ir_valid update on the edge at which ack is sampled. Minimum LoadIR-to-instruction time is 2 edges.
- imem_ack while in IDLE is ignored.
- instruction holds its value until the next successful fetch.
- All outputs are registered.

Test Plan:
1. Reset with RESET_PC=0 → pc=0, instruction=0, imem_req=0. LoadIR pulse, then ack one cycle later with rdata=32'h00500093 → imem_addr=0, instruction=32'h00500093, ir_valid=1, fetch_busy=0.
2. PCWrite=1, PCSrc=00, alu_result=4 → pc=4 next cycle. With pc=4: PCWriteCond=1, BranchOp=00, alu_zero=1, alu_out=32'h40, PCSrc=01 → pc=32'h40. Repeat with alu_zero=0 → pc stays 4.
3. BranchOp=11, alu_lt=1, target 32'h20 → pc=32'h20. Then BranchOp=10, alu_lt=1 → pc unchanged.
4. PCSrc=10, PCWrite=1 → pc=32'h000000FC. Then PCWrite with alu_out=32'h42, PCSrc=01 → pc unchanged, misaligned pulses for exactly 1 cycle.
5. LoadIR with no ack, TIMEOUT=8 → imem_req high for exactly 8 cycles, then fetch_err pulses once, ir_valid=0, instruction keeps its prior value. A second LoadIR sent during WAIT has no effect.
6. Assert Reset mid-WAIT → imem_req=0 immediately, pc=RESET_PC. An ack arriving one cycle after reset release leaves instruction=0 and ir_valid=0.
